wqe_fetch: RTL and testbench

WQE_FETCH -- requirements
Module: wqe_fetch

---
 rtl/wqe_fetch_pkg.sv | 8 +
 rtl/gen_sfifo.sv | 41 ++++
 rtl/wqe_fetch.sv | 156 +++++++++++++++
 tb/tb_wqe_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wqe_fetch_pkg.sv
// wqe_fetch_pkg: shared constants and FSM encoding for the WQE fetch engine
package wqe_fetch_pkg;
    localparam int WQE_SHIFT = 6;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;
endpackage

// File: rtl/gen_sfifo.sv
// gen_sfifo: show-ahead synchronous FIFO, head word visible while non-empty
module gen_sfifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);
    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (cnt_q != (DEPTH_LOG2+1)'(2**DEPTH_LOG2) || do_pop);
    assign rdata_o = mem_q[rd_q];

    // pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + DEPTH_LOG2'(do_push);
            rd_q  <= rd_q + DEPTH_LOG2'(do_pop);
            cnt_q <= cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    // storage array, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/wqe_fetch.sv
// wqe_fetch: per-QP doorbell accounting, round-robin WQE DMA fetch and in-order delivery to the WQE cache
module wqe_fetch
    import wqe_fetch_pkg::*;
#(
    parameter int WQE_WIDTH       = 512,
    parameter int QP_PTR_WIDTH    = 4,
    parameter int SQ_DEPTH_LOG2   = 8,
    parameter int DB_CNT_WIDTH    = 16,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_cfg_wen,
    input  logic [QP_PTR_WIDTH-1:0] i_cfg_qpn,
    input  logic [ADDR_WIDTH-1:0]   i_cfg_base,
    input  logic                    i_db_val,
    input  logic [QP_PTR_WIDTH-1:0] i_db_qpn,
    input  logic [DB_CNT_WIDTH-1:0] i_db_cnt,
    output logic                    o_db_ovf,
    output logic                    o_dma_rd_req_val,
    input  logic                    i_dma_rd_req_rdy,
    output logic [ADDR_WIDTH-1:0]   o_dma_rd_req_addr,
    output logic [QP_PTR_WIDTH-1:0] o_dma_rd_req_qpn,
    input  logic                    i_dma_rd_rsp_val,
    input  logic [WQE_WIDTH-1:0]    i_dma_rd_rsp_data,
    output logic                    o_rsp_err,
    output logic                    o_wqe_cache_wr,
    output logic [WQE_WIDTH-1:0]    o_wqe,
    input  logic                    i_wqe_cache_alfull
);
    localparam int NQ = 2 ** QP_PTR_WIDTH;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FD = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     base_q [NQ];
    logic [DB_CNT_WIDTH-1:0]   pend_q [NQ];
    logic [DB_CNT_WIDTH-1:0]   pend_d [NQ];
    logic [SQ_DEPTH_LOG2-1:0]  fidx_q [NQ];
    logic [QP_PTR_WIDTH-1:0]   sel_q, sel_d, rr_q, rr_d, pick;
    logic [DB_CNT_WIDTH:0]     sum;
    logic [CW-1:0]             rsv_q, inf_q;
    logic [WQE_WIDTH-1:0]      wqe_q, head;
    logic                      found, acc, push, pop, empty, ovf_d, ovf_q, err_q, wr_q;

    assign push              = i_dma_rd_rsp_val && inf_q != '0;
    assign pop               = !empty && !i_wqe_cache_alfull;
    assign o_dma_rd_req_val  = state_q == ST_REQ;
    assign o_dma_rd_req_qpn  = sel_q;
    assign o_dma_rd_req_addr = base_q[sel_q] + (ADDR_WIDTH'(fidx_q[sel_q]) << WQE_SHIFT);
    assign o_db_ovf          = ovf_q;
    assign o_rsp_err         = err_q;
    assign o_wqe_cache_wr    = wr_q;
    assign o_wqe             = wqe_q;

    // round-robin search for the first QP with pending work, starting at rr_q
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int i = 0; i < NQ; i++) begin
            if (!found && pend_q[rr_q + QP_PTR_WIDTH'(i)] != '0) begin
                found = 1'b1;
                pick  = rr_q + QP_PTR_WIDTH'(i);
            end
        end
    end

    // IDLE/REQ sequencing; rr_q holds the QP after the last grant
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        acc     = state_q == ST_REQ && i_dma_rd_req_rdy;
        if (state_q == ST_IDLE && found && rsv_q < CW'(MAX_OUTSTANDING)) begin
            state_d = ST_REQ;
            sel_d   = pick;
        end
        if (acc) begin
            state_d = ST_IDLE;
            rr_d    = sel_q + 1'b1;
        end
    end

    // pending update: add doorbell, subtract accepted request, saturate on overflow
    always_comb begin
        ovf_d = 1'b0;
        sum   = '0;
        for (int q = 0; q < NQ; q++) begin
            sum = {1'b0, pend_q[q]}
                + ((i_db_val && i_db_qpn == QP_PTR_WIDTH'(q)) ? {1'b0, i_db_cnt} : '0)
                - (DB_CNT_WIDTH+1)'(acc && sel_q == QP_PTR_WIDTH'(q));
            pend_d[q] = sum[DB_CNT_WIDTH] ? '1 : sum[DB_CNT_WIDTH-1:0];
            ovf_d     = ovf_d | sum[DB_CNT_WIDTH];
        end
    end

    // per-QP base, pending and fetch index state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NQ; q++) begin
                base_q[q] <= '0;
                pend_q[q] <= '0;
                fidx_q[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NQ; q++) begin
                pend_q[q] <= pend_d[q];
                if (i_cfg_wen && i_cfg_qpn == QP_PTR_WIDTH'(q)) begin
                    base_q[q] <= i_cfg_base;
                    fidx_q[q] <= '0;
                end else if (acc && sel_q == QP_PTR_WIDTH'(q)) begin
                    fidx_q[q] <= fidx_q[q] + 1'b1;
                end
            end
        end
    end

    // FSM, credit counters and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            rsv_q   <= '0;
            inf_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wqe_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            rsv_q   <= rsv_q + CW'(acc) - CW'(pop);
            inf_q   <= inf_q + CW'(acc) - CW'(push);
            ovf_q   <= ovf_d;
            err_q   <= i_dma_rd_rsp_val && inf_q == '0;
            wr_q    <= pop;
            if (pop) wqe_q <= head;
        end
    end

    gen_sfifo #(
        .WIDTH      (WQE_WIDTH),
        .DEPTH_LOG2 (FD)
    ) u_rsp_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (i_dma_rd_rsp_data),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_wqe_fetch.sv
// tb_wqe_fetch: directed scenario bench for wqe_fetch
module tb_wqe_fetch;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_cfg_wen = 1'b0;
    logic [3:0]   i_cfg_qpn = '0;
    logic [63:0]  i_cfg_base = '0;
    logic         i_db_val = 1'b0;
    logic [3:0]   i_db_qpn = '0;
    logic [15:0]  i_db_cnt = '0;
    logic         o_db_ovf;
    logic         o_dma_rd_req_val;
    logic         i_dma_rd_req_rdy = 1'b0;
    logic [63:0]  o_dma_rd_req_addr;
    logic [3:0]   o_dma_rd_req_qpn;
    logic         i_dma_rd_rsp_val = 1'b0;
    logic [511:0] i_dma_rd_rsp_data = '0;
    logic         o_rsp_err;
    logic         o_wqe_cache_wr;
    logic [511:0] o_wqe;
    logic         i_wqe_cache_alfull = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int ovf_cnt = 0;
    int err_cnt = 0;
    bit auto_rsp = 1'b1;
    logic [63:0]  addr_log [$];
    logic [3:0]   qpn_log [$];
    logic [511:0] wqe_log [$];

    wqe_fetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_cfg_wen          (i_cfg_wen),
        .i_cfg_qpn          (i_cfg_qpn),
        .i_cfg_base         (i_cfg_base),
        .i_db_val           (i_db_val),
        .i_db_qpn           (i_db_qpn),
        .i_db_cnt           (i_db_cnt),
        .o_db_ovf           (o_db_ovf),
        .o_dma_rd_req_val   (o_dma_rd_req_val),
        .i_dma_rd_req_rdy   (i_dma_rd_req_rdy),
        .o_dma_rd_req_addr  (o_dma_rd_req_addr),
        .o_dma_rd_req_qpn   (o_dma_rd_req_qpn),
        .i_dma_rd_rsp_val   (i_dma_rd_rsp_val),
        .i_dma_rd_rsp_data  (i_dma_rd_rsp_data),
        .o_rsp_err          (o_rsp_err),
        .o_wqe_cache_wr     (o_wqe_cache_wr),
        .o_wqe              (o_wqe),
        .i_wqe_cache_alfull (i_wqe_cache_alfull)
    );

    always #5 clk = ~clk;

    // one clock: log the handshake seen at the edge, act as in-order DMA responder, record pulses
    task automatic tick();
        logic        acc;
        logic [63:0] a;
        logic [3:0]  qn;
        @(negedge clk);
        acc = o_dma_rd_req_val && i_dma_rd_req_rdy;
        a   = o_dma_rd_req_addr;
        qn  = o_dma_rd_req_qpn;
        @(posedge clk);
        #1;
        if (acc) begin
            addr_log.push_back(a);
            qpn_log.push_back(qn);
        end
        i_dma_rd_rsp_val  = auto_rsp && acc;
        i_dma_rd_rsp_data = 512'(a);
        if (o_wqe_cache_wr) wqe_log.push_back(o_wqe);
        ovf_cnt += int'(o_db_ovf);
        err_cnt += int'(o_rsp_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_cfg_wen = 1'b0;
        i_db_val = 1'b0;
        i_dma_rd_req_rdy = 1'b0;
        i_dma_rd_rsp_val = 1'b0;
        i_wqe_cache_alfull = 1'b0;
        auto_rsp = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        addr_log.delete();
        qpn_log.delete();
        wqe_log.delete();
        ovf_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic cfg(input logic [3:0] q, input logic [63:0] b);
        i_cfg_wen = 1'b1;
        i_cfg_qpn = q;
        i_cfg_base = b;
        tick();
        i_cfg_wen = 1'b0;
    endtask

    task automatic db(input logic [3:0] q, input logic [15:0] c);
        i_db_val = 1'b1;
        i_db_qpn = q;
        i_db_cnt = c;
        tick();
        i_db_val = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({o_dma_rd_req_val, o_wqe_cache_wr, o_db_ovf, o_rsp_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b exp 0000", {o_dma_rd_req_val, o_wqe_cache_wr, o_db_ovf, o_rsp_err});
        end
        n_tests++;
        if (o_dma_rd_req_addr !== 64'h0 || o_dma_rd_req_qpn !== 4'h0 || o_wqe !== 512'h0) begin
            n_fail++;
            $display("FAIL reset_data got addr %h qpn %h exp 0", o_dma_rd_req_addr, o_dma_rd_req_qpn);
        end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        cfg(4'd1, 64'h1000);
        db(4'd1, 16'd3);
        n_tests++;
        if (o_dma_rd_req_val !== 1'b0) begin
            n_fail++;
            $display("FAIL val_at_n1 got %b exp 0", o_dma_rd_req_val);
        end
        tick();
        n_tests++;
        if (o_dma_rd_req_val !== 1'b1 || o_dma_rd_req_addr !== 64'h1000 || o_dma_rd_req_qpn !== 4'd1) begin
            n_fail++;
            $display("FAIL val_at_n2 got val %b addr %h qpn %h exp 1 1000 1", o_dma_rd_req_val, o_dma_rd_req_addr, o_dma_rd_req_qpn);
        end
        tick();
        n_tests++;
        if (o_dma_rd_req_val !== 1'b1 || o_dma_rd_req_addr !== 64'h1000) begin
            n_fail++;
            $display("FAIL req_hold got val %b addr %h exp 1 1000", o_dma_rd_req_val, o_dma_rd_req_addr);
        end
        i_dma_rd_req_rdy = 1'b1;
        repeat (12) tick();
        n_tests++;
        if (addr_log.size() !== 3) begin
            n_fail++;
            $display("FAIL basic_req_count got %0d exp 3", addr_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (addr_log[i] !== 64'h1000 + 64'(i) * 64'h40) begin
                n_fail++;
                $display("FAIL basic_addr%0d got %h exp %h", i, addr_log[i], 64'h1000 + 64'(i) * 64'h40);
            end
        end
        n_tests++;
        if (wqe_log.size() !== 3 || wqe_log[2] !== 512'h1080) begin
            n_fail++;
            $display("FAIL basic_writes got %0d last %h exp 3 1080", wqe_log.size(), wqe_log[2][63:0]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_q [4] = '{4'd0, 4'd2, 4'd0, 4'd2};
        logic [63:0] exp_a [4] = '{64'h0, 64'h2000, 64'h40, 64'h2040};
        do_reset();
        cfg(4'd2, 64'h2000);
        i_dma_rd_req_rdy = 1'b1;
        db(4'd0, 16'd2);
        db(4'd2, 16'd2);
        repeat (14) tick();
        n_tests++;
        if (qpn_log.size() !== 4) begin
            n_fail++;
            $display("FAIL rr_count got %0d exp 4", qpn_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (qpn_log[i] !== exp_q[i] || addr_log[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL rr_grant%0d got qpn %h addr %h exp %h %h", i, qpn_log[i], addr_log[i], exp_q[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cfg(4'd3, 64'h3000);
        i_wqe_cache_alfull = 1'b1;
        i_dma_rd_req_rdy = 1'b1;
        db(4'd3, 16'd10);
        repeat (20) tick();
        n_tests++;
        if (addr_log.size() !== 4 || wqe_log.size() !== 0) begin
            n_fail++;
            $display("FAIL alfull_hold got reqs %0d writes %0d exp 4 0", addr_log.size(), wqe_log.size());
        end
        i_wqe_cache_alfull = 1'b0;
        repeat (40) tick();
        n_tests++;
        if (addr_log.size() !== 10 || wqe_log.size() !== 10) begin
            n_fail++;
            $display("FAIL alfull_release got reqs %0d writes %0d exp 10 10", addr_log.size(), wqe_log.size());
        end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (wqe_log[i] !== 512'(64'h3000 + 64'(i) * 64'h40)) begin
                n_fail++;
                $display("FAIL alfull_wqe%0d got %h exp %h", i, wqe_log[i][63:0], 64'h3000 + 64'(i) * 64'h40);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        db(4'd5, 16'hFFFE);
        tick();
        n_tests++;
        if (ovf_cnt !== 0) begin
            n_fail++;
            $display("FAIL sat_no_ovf got %0d pulses exp 0", ovf_cnt);
        end
        db(4'd5, 16'd5);
        n_tests++;
        if (o_db_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pulse got %b exp 1", o_db_ovf);
        end
        tick();
        tick();
        n_tests++;
        if (ovf_cnt !== 1 || o_dma_rd_req_val !== 1'b1 || o_dma_rd_req_qpn !== 4'd5) begin
            n_fail++;
            $display("FAIL sat_once got pulses %0d val %b qpn %h exp 1 1 5", ovf_cnt, o_dma_rd_req_val, o_dma_rd_req_qpn);
        end
        i_dma_rd_req_rdy = 1'b1;
        db(4'd5, 16'd1);
        i_dma_rd_req_rdy = 1'b0;
        tick();
        tick();
        n_tests++;
        if (ovf_cnt !== 1 || addr_log.size() !== 1) begin
            n_fail++;
            $display("FAIL sat_db_and_acc got pulses %0d reqs %0d exp 1 1", ovf_cnt, addr_log.size());
        end
    endtask

    task automatic test_index_wrap();
        do_reset();
        cfg(4'd7, 64'h10000);
        i_dma_rd_req_rdy = 1'b1;
        db(4'd7, 16'd257);
        repeat (600) tick();
        n_tests++;
        if (addr_log.size() !== 257) begin
            n_fail++;
            $display("FAIL wrap_count got %0d exp 257", addr_log.size());
        end
        n_tests++;
        if (addr_log[255] !== 64'h13FC0) begin
            n_fail++;
            $display("FAIL wrap_idx255 got %h exp 13fc0", addr_log[255]);
        end
        n_tests++;
        if (addr_log[256] !== 64'h10000) begin
            n_fail++;
            $display("FAIL wrap_idx0 got %h exp 10000", addr_log[256]);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        cfg(4'd1, 64'h1000);
        auto_rsp = 1'b0;
        i_dma_rd_req_rdy = 1'b1;
        db(4'd1, 16'd3);
        repeat (5) tick();
        n_tests++;
        if (addr_log.size() !== 2 || o_dma_rd_req_val !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_setup got reqs %0d val %b exp 2 1", addr_log.size(), o_dma_rd_req_val);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_dma_rd_req_val !== 1'b0 || o_dma_rd_req_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset got val %b addr %h exp 0 0", o_dma_rd_req_val, o_dma_rd_req_addr);
        end
        i_dma_rd_req_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        err_cnt = 0;
        wqe_log.delete();
        i_dma_rd_rsp_data = 512'h1000;
        i_dma_rd_rsp_val = 1'b1;
        tick();
        i_dma_rd_rsp_data = 512'h1040;
        i_dma_rd_rsp_val = 1'b1;
        tick();
        repeat (4) tick();
        n_tests++;
        if (err_cnt !== 2 || wqe_log.size() !== 0) begin
            n_fail++;
            $display("FAIL stale_rsp got errs %0d writes %0d exp 2 0", err_cnt, wqe_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_index_wrap();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
